// File: rtl/calc_sequencer.sv
// calc_sequencer
// Single-clock controller for the two-digit keypad calculator. Sequences
// operand entry (A tens/ones, operator, B tens/ones) from debounced key
// events. On Equal it launches the shared multi-cycle ALU through a
// start/done handshake and latches the result for the display path.
// It also handles clear-abort (including a result still in flight), ALU
// timeout and error reporting. All outputs come straight from registers.
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 64,
  parameter int RESULT_W    = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [7:0]          key_code,
  output logic                alu_start,
  output logic [6:0]          alu_a,
  output logic [6:0]          alu_b,
  output logic [1:0]          alu_op,
  input  logic                alu_done,
  input  logic                alu_err,
  input  logic [RESULT_W-1:0] alu_result,
  output logic [3:0]          disp_stage,
  output logic [3:0]          disp_hi,
  output logic [3:0]          disp_lo,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                error,
  output logic                busy
);

  // The timeout counter only has to reach ALU_TIMEOUT-1.
  localparam int            TW       = $clog2(ALU_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT - 1);
  localparam logic [3:0]    BLANK    = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A1,
    S_A0,
    S_OP,
    S_B1,
    S_B0,
    S_CALC,
    S_SHOW,
    S_ERR
  } state_t;

  // ------------------------------------------------------------------
  // Key decode. Codes that match none of these classes are ignored.
  // ------------------------------------------------------------------
  logic [3:0] key_val;
  logic       key_digit;
  logic       key_oper;
  logic       key_equal;
  logic       key_clear;

  assign key_val   = key_code[3:0];
  assign key_digit = key_valid && !key_code[7] && (key_val <= 4'd9);
  assign key_oper  = key_valid && (key_code[7:4] == 4'hF);
  assign key_equal = key_valid && (key_code == 8'hEE);
  assign key_clear = key_valid && (key_code == 8'hCC);

  // Binary value of a two-digit decimal entry: tens*10 + ones.
  function automatic logic [6:0] two_digit(input logic [3:0] tens,
                                           input logic [3:0] ones);
    logic [6:0] t7;
    t7 = {3'b000, tens};
    return (t7 << 3) + (t7 << 1) + {3'b000, ones};
  endfunction

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  state_t                state_q, state_d;
  logic                  alu_start_q, alu_start_d;
  logic [6:0]            alu_a_q, alu_a_d;
  logic [6:0]            alu_b_q, alu_b_d;
  logic [1:0]            alu_op_q, alu_op_d;
  logic [3:0]            tens_q, tens_d;
  logic [3:0]            disp_stage_q, disp_stage_d;
  logic [3:0]            disp_hi_q, disp_hi_d;
  logic [3:0]            disp_lo_q, disp_lo_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  // discard: an aborted ALU operation is still running; its done is swallowed.
  logic                  discard_q, discard_d;
  // eq_pend: Equal arrived in B0 while discard was set; launch once it clears.
  logic                  eq_pend_q, eq_pend_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  // Next-state and registered-output logic for the entry/launch sequence
  always_comb begin
    state_d        = state_q;
    alu_start_d    = 1'b0;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    tens_d         = tens_q;
    disp_stage_d   = disp_stage_q;
    disp_hi_d      = disp_hi_q;
    disp_lo_d      = disp_lo_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    error_d        = error_q;
    busy_d         = busy_q;
    discard_d      = discard_q;
    eq_pend_d      = eq_pend_q;
    tmo_d          = tmo_q;

    // The first done after an abort belongs to the abandoned operation.
    if (alu_done && discard_q) begin
      discard_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_SHOW: begin
        if (key_digit) begin
          state_d        = S_A1;
          tens_d         = key_val;
          disp_stage_d   = 4'd1;
          disp_hi_d      = BLANK;
          disp_lo_d      = key_val;
          result_valid_d = 1'b0;
        end
      end

      S_A1: begin
        if (key_digit) begin
          state_d      = S_A0;
          alu_a_d      = two_digit(tens_q, key_val);
          disp_stage_d = 4'd2;
          disp_hi_d    = tens_q;
          disp_lo_d    = key_val;
        end
      end

      S_A0: begin
        if (key_oper) begin
          state_d      = S_OP;
          alu_op_d     = key_code[1:0];
          disp_stage_d = 4'd3;
          disp_hi_d    = BLANK;
          disp_lo_d    = BLANK;
        end
      end

      S_OP: begin
        if (key_digit) begin
          state_d      = S_B1;
          tens_d       = key_val;
          disp_stage_d = 4'd3;
          disp_hi_d    = BLANK;
          disp_lo_d    = key_val;
        end
      end

      S_B1: begin
        if (key_digit) begin
          state_d      = S_B0;
          alu_b_d      = two_digit(tens_q, key_val);
          disp_stage_d = 4'd4;
          disp_hi_d    = tens_q;
          disp_lo_d    = key_val;
        end
      end

      S_B0: begin
        // Never launch while the ALU may still be busy with an aborted job.
        if ((key_equal || eq_pend_q) && !discard_q) begin
          state_d     = S_CALC;
          alu_start_d = 1'b1;
          busy_d      = 1'b1;
          tmo_d       = '0;
          eq_pend_d   = 1'b0;
        end else if (key_equal) begin
          eq_pend_d = 1'b1;
        end
      end

      S_CALC: begin
        // A done on the last allowed cycle still counts as success.
        if (alu_done) begin
          busy_d = 1'b0;
          if (alu_err) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d        = S_SHOW;
            result_d       = alu_result;
            result_valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_ERR: begin
        // Only Clear leaves; handled below.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear overrides whatever the state logic decided.
    if (key_clear) begin
      state_d        = S_IDLE;
      alu_start_d    = 1'b0;
      alu_a_d        = '0;
      alu_b_d        = '0;
      alu_op_d       = '0;
      tens_d         = '0;
      disp_stage_d   = 4'd0;
      disp_hi_d      = BLANK;
      disp_lo_d      = BLANK;
      result_valid_d = 1'b0;
      error_d        = 1'b0;
      busy_d         = 1'b0;
      eq_pend_d      = 1'b0;
      tmo_d          = '0;
      // Abort mid-calculation: the ALU keeps running, so its done must be
      // ignored later. If done lands on this very cycle nothing is left.
      if (state_q == S_CALC && !alu_done) begin
        discard_d = 1'b1;
      end
    end
  end

  // State register and registered outputs, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      alu_start_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      tens_q         <= '0;
      disp_stage_q   <= 4'd0;
      disp_hi_q      <= BLANK;
      disp_lo_q      <= BLANK;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      busy_q         <= 1'b0;
      discard_q      <= 1'b0;
      eq_pend_q      <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      alu_start_q    <= alu_start_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      tens_q         <= tens_d;
      disp_stage_q   <= disp_stage_d;
      disp_hi_q      <= disp_hi_d;
      disp_lo_q      <= disp_lo_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      busy_q         <= busy_d;
      discard_q      <= discard_d;
      eq_pend_q      <= eq_pend_d;
      tmo_q          <= tmo_d;
    end
  end

  assign alu_start    = alu_start_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign disp_stage   = disp_stage_q;
  assign disp_hi      = disp_hi_q;
  assign disp_lo      = disp_lo_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: keypad driver, behavioural ALU responder,
// and a scoreboard monitor that checks launches and calculation outcomes.
`timescale 1ns/1ps
module tb_calc_sequencer;

  localparam int T  = 64;
  localparam int RW = 14;

  logic          clk;
  logic          rst;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          alu_start;
  logic [6:0]    alu_a;
  logic [6:0]    alu_b;
  logic [1:0]    alu_op;
  logic          alu_done;
  logic          alu_err;
  logic [RW-1:0] alu_result;
  logic [3:0]    disp_stage;
  logic [3:0]    disp_hi;
  logic [3:0]    disp_lo;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          error;
  logic          busy;

  calc_sequencer #(.ALU_TIMEOUT(T), .RESULT_W(RW)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .disp_stage(disp_stage), .disp_hi(disp_hi), .disp_lo(disp_lo),
    .result(result), .result_valid(result_valid), .error(error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [6:0] a; logic [6:0] b; logic [1:0] op; } launch_t;
  typedef struct { bit is_err; bit via_done; logic [RW-1:0] res; int busy_len; } outcome_t;
  launch_t  launch_q[$];
  outcome_t outcome_q[$];

  // ALU responder controls (captured at each alu_start)
  int alu_lat       = 5;
  bit alu_mute      = 1'b0;
  bit alu_force_err = 1'b0;
  int done_count    = 0;
  bit model_err     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Arithmetic performed by the stand-in ALU.
  function automatic logic [RW-1:0] alu_fn(input int a, input int b, input int op);
    case (op)
      0:       return RW'(a * b);
      1:       return RW'(a + b);
      2:       return RW'(a - b);
      default: return (b == 0) ? '0 : RW'(a / b);
    endcase
  endfunction

  function automatic logic [7:0] junk_code();
    logic [7:0] tbl [5] = '{8'h0C, 8'h0F, 8'hAB, 8'h80, 8'h7A};
    return tbl[$urandom_range(4)];
  endfunction

  task automatic press(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
    $display("key %02h -> stage=%0d hi=%h lo=%h", c, disp_stage, disp_hi, disp_lo);
  endtask

  task automatic chk_disp(input string n, input int s, input int h, input int l);
    chk(n, {disp_stage, disp_hi, disp_lo}, (s << 8) | (h << 4) | l);
  endtask

  task automatic check_reset_values(input string n);
    chk(n, {alu_start, alu_a, alu_b, alu_op, disp_stage, disp_hi, disp_lo,
            result_valid, error, busy},
        {1'b0, 7'd0, 7'd0, 2'd0, 4'd0, 4'hF, 4'hF, 3'b000});
    chk({n, "_result"}, result, 0);
  endtask

  // Enter "a op b" digit by digit, optionally sprinkling ignored keys.
  task automatic enter_op(input int a, input int b, input int op, input bit junk);
    int at, ao, bt, bo;
    at = a / 10; ao = a % 10; bt = b / 10; bo = b % 10;
    press(8'(at));
    chk_disp("disp_A1", 1, 15, at);
    chk("rv_cleared_on_entry", result_valid, 0);
    if (junk) begin
      press(junk_code());
      chk_disp("junk_in_A1", 1, 15, at);
      press(8'hEE);
      chk_disp("equal_in_A1", 1, 15, at);
    end
    press(8'(ao));
    chk_disp("disp_A0", 2, at, ao);
    chk("alu_a", alu_a, a);
    if (junk) begin
      press(8'h05);
      chk_disp("digit_in_A0", 2, at, ao);
      chk("alu_a_kept", alu_a, a);
    end
    press(8'hF0 | 8'(op));
    chk_disp("disp_OP", 3, 15, 15);
    chk("alu_op", alu_op, op);
    if (junk) begin
      press(8'hF0 | 8'((op + 1) % 4));
      chk("alu_op_kept", alu_op, op);
    end
    press(8'(bt));
    chk_disp("disp_B1", 3, 15, bt);
    if (junk) begin
      press(junk_code());
      chk_disp("junk_in_B1", 3, 15, bt);
    end
    press(8'(bo));
    chk_disp("disp_B0", 4, bt, bo);
    chk("alu_b", alu_b, b);
    if (junk) begin
      press(8'h07);
      chk_disp("digit_in_B0", 4, bt, bo);
      chk("alu_b_kept", alu_b, b);
    end
  endtask

  // mode: 0 normal, 1 forced ALU error, 2 ALU never answers.
  task automatic launch(input int a, input int b, input int op, input int lat,
                        input int mode, input bit held);
    launch_t  l;
    outcome_t o;
    alu_lat       = lat;
    alu_force_err = (mode == 1);
    alu_mute      = (mode == 2);
    l.a = 7'(a); l.b = 7'(b); l.op = 2'(op);
    launch_q.push_back(l);
    o.is_err   = (mode != 0) || (op == 3 && b == 0);
    o.via_done = (mode != 2);
    o.res      = o.is_err ? '0 : alu_fn(a, b, op);
    o.busy_len = (mode == 2) ? T : lat + 1;
    outcome_q.push_back(o);
    model_err = o.is_err;
    press(8'hEE);
    chk(held ? "equal_held_in_B0" : "busy_on_launch", busy, held ? 0 : 1);
  endtask

  task automatic wait_outcome(input string n);
    int k;
    k = 0;
    while (outcome_q.size() != 0 && k < T + 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk(n, outcome_q.size(), 0);
    chk({n, "_launches"}, launch_q.size(), 0);
    outcome_q.delete();
    launch_q.delete();
  endtask

  // Behavioural ALU: answers alu_lat cycles after alu_start.
  initial begin
    int cnt; bit pend; bit m_mute; bit m_err;
    logic [6:0] ca, cb; logic [1:0] cop;
    alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
    pend = 0; cnt = 0; m_mute = 0; m_err = 0; ca = 0; cb = 0; cop = 0;
    forever begin
      @(posedge clk); #1;
      alu_done = 1'b0;
      alu_err  = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (alu_start) begin
        pend = 1; cnt = alu_lat; m_mute = alu_mute; m_err = alu_force_err;
        ca = alu_a; cb = alu_b; cop = alu_op;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          if (!m_mute) begin
            alu_done   = 1'b1;
            alu_err    = m_err || (cop == 2'd3 && cb == 7'd0);
            alu_result = alu_err ? '0 : alu_fn(int'(ca), int'(cb), int'(cop));
            done_count++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: checks every launch and every outcome.
  initial begin
    bit prev_rv, prev_err, prev_start, prev_done;
    int busy_cnt;
    launch_t  l;
    outcome_t o;
    prev_rv = 0; prev_err = 0; prev_start = 0; prev_done = 0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 0; prev_err = 0; prev_start = 0; prev_done = 0; busy_cnt = 0;
      end else begin
        if (alu_start) begin
          chk("start_single_pulse", prev_start, 0);
          busy_cnt = 0;
          chk("launch_expected", launch_q.size() > 0, 1);
          if (launch_q.size() > 0) begin
            l = launch_q.pop_front();
            chk("launch_a", alu_a, l.a);
            chk("launch_b", alu_b, l.b);
            chk("launch_op", alu_op, l.op);
            $display("launch a=%0d b=%0d op=%0d", alu_a, alu_b, alu_op);
          end
        end
        if (busy) busy_cnt++;
        if ((result_valid && !prev_rv) || (error && !prev_err)) begin
          chk("outcome_expected", outcome_q.size() > 0, 1);
          if (outcome_q.size() > 0) begin
            o = outcome_q.pop_front();
            chk("outcome_error", error, o.is_err);
            chk("outcome_valid", result_valid, !o.is_err);
            if (!o.is_err) chk("outcome_result", result, o.res);
            chk("busy_cycles", busy_cnt, o.busy_len);
            if (o.via_done) chk("done_to_output_latency", prev_done, 1);
            $display("outcome err=%0d result=%0d busy=%0d", error, result, busy_cnt);
          end
        end
        prev_rv = result_valid; prev_err = error;
        prev_start = alu_start; prev_done = alu_done;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    launch_t l;
    int dc0, k;
    int a, b, op, lat, mode;
    bit junk;
    rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Basic 12 + 34
    enter_op(12, 34, 1, 0);
    launch(12, 34, 1, 5, 0, 0);
    wait_outcome("t1_outcome");
    chk("t1_result", result, 46);
    chk("t1_operands_held", {alu_a, alu_b, alu_op}, {7'd12, 7'd34, 2'd1});
    press(8'hEE);
    chk("equal_in_show_ignored", result_valid, 1);

    // ALU error, then key behaviour in ERR, Clear, ignored keys in IDLE
    enter_op(99, 0, 2, 1);
    launch(99, 0, 2, 4, 1, 0);
    wait_outcome("t2_outcome");
    chk("t2_rv_low", result_valid, 0);
    press(8'h03);
    chk("digit_in_err_ignored", error, 1);
    chk_disp("err_disp_held", 4, 0, 0);
    press(8'hCC);
    chk_disp("clear_disp", 0, 15, 15);
    chk("clear_flags", {error, result_valid, busy}, 0);
    chk("clear_operands", {alu_a, alu_b, alu_op}, 0);
    press(8'h0C);
    chk_disp("invalid_in_idle", 0, 15, 15);
    press(8'hF1);
    press(8'hEE);
    chk_disp("op_equal_in_idle", 0, 15, 15);

    // Timeout, then done on the last allowed cycle
    enter_op(57, 8, 0, 0);
    launch(57, 8, 0, 10, 2, 0);
    wait_outcome("t3_timeout");
    chk("t3_error", error, 1);
    press(8'hCC);
    enter_op(57, 8, 0, 0);
    launch(57, 8, 0, T - 1, 0, 0);
    wait_outcome("t3_done_wins");
    chk("t3_result", result, 456);

    // Clear during CALC: the late done is swallowed, a new Equal waits for it
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset2");
    enter_op(21, 43, 1, 0);
    alu_lat = 20; alu_mute = 0; alu_force_err = 0;
    l.a = 7'd21; l.b = 7'd43; l.op = 2'd1;
    launch_q.push_back(l);
    press(8'hEE);
    press(8'hCC);
    chk_disp("t4_clear", 0, 15, 15);
    chk("t4_busy_low", busy, 0);
    dc0 = done_count;
    enter_op(11, 11, 1, 0);
    launch(11, 11, 1, 3, 0, 1);
    k = 0;
    while (done_count == dc0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t4_late_done_seen", done_count, dc0 + 1);
    @(negedge clk);
    chk("t4_result_not_latched", result, 0);
    chk("t4_rv_low", result_valid, 0);
    chk("t4_launch_after_done", launch_q.size(), 1);
    wait_outcome("t4_relaunch");
    chk("t4_result", result, 22);

    // Asynchronous reset in the middle of a calculation
    enter_op(33, 44, 0, 0);
    launch(33, 44, 0, 30, 0, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    outcome_q.delete();
    launch_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    enter_op(84, 2, 3, 0);
    launch(84, 2, 3, 2, 0, 0);
    wait_outcome("post_rst_launch");

    // Randomised operations
    for (int it = 0; it < 25; it++) begin
      a    = $urandom_range(99);
      b    = $urandom_range(99);
      op   = $urandom_range(3);
      lat  = $urandom_range(1, 8);
      mode = ($urandom_range(7) == 0) ? 1 : 0;
      junk = 1'($urandom_range(1));
      if (model_err) begin
        press(8'hCC);
        chk_disp("rand_clear", 0, 15, 15);
      end
      enter_op(a, b, op, junk);
      launch(a, b, op, lat, mode, 0);
      wait_outcome("rand_outcome");
    end

    chk("queues_empty", launch_q.size() + outcome_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
